// File: rtl/poker_pkg.sv
// Shared card/hand types for the poker hand-rank datapath.
// Cards are {rank, suit}: rank 0=2 .. 12=A, suit 0=C 1=D 2=H 3=S.
package poker_pkg;

  localparam int unsigned NUM_RANKS = 13;
  localparam int unsigned NUM_SUITS = 4;
  localparam int unsigned RANK_W    = 4;
  localparam int unsigned SUIT_W    = 2;
  localparam int unsigned CARD_W    = RANK_W + SUIT_W;

  typedef logic [RANK_W-1:0] rank_t;
  typedef logic [SUIT_W-1:0] suit_t;

  typedef struct packed {
    rank_t rank;
    suit_t suit;
  } card_t;

  // Highest legal rank code (Ace); anything above is an illegal card.
  localparam rank_t MAX_RANK = 4'd12;

  typedef enum logic [3:0] {
    HIGH_CARD      = 4'd0,
    PAIR           = 4'd1,
    TWO_PAIR       = 4'd2,
    THREE_KIND     = 4'd3,
    STRAIGHT       = 4'd4,
    FLUSH          = 4'd5,
    FULL_HOUSE     = 4'd6,
    FOUR_KIND      = 4'd7,
    STRAIGHT_FLUSH = 4'd8,
    ROYAL_FLUSH    = 4'd9
  } hand_rank_e;

endpackage

// File: rtl/straight_detect.sv
// Combinational 5-in-a-row detector over a 13-bit rank mask (bit 0 = 2, bit 12 = A).
// Ports:
//   mask     in  13  set of ranks present
//   found    out 1   mask holds five consecutive ranks, or the wheel A-2-3-4-5
//   ace_high out 1   mask holds 10-J-Q-K-A
module straight_detect
  import poker_pkg::*;
(
  input  logic [12:0] mask,
  output logic        found,
  output logic        ace_high
);

  // Wheel uses the Ace as the low card; no K-A-2 wrap beyond that.
  always_comb begin
    found = &{mask[12], mask[3:0]};
    for (int unsigned lo = 0; lo <= 8; lo++) begin
      if (&mask[lo +: 5]) found = 1'b1;
    end
    ace_high = &mask[12:8];
  end

endmodule

// File: rtl/hand_rank_stream_eval.sv
// Streaming poker-hand classifier. Takes HAND_SIZE cards over valid/ready,
// stores them as per-suit rank masks, then reports the best 5-card hand.
// Optional macro: HAND_ROYAL_FLUSH_EN (10-J-Q-K-A straight flush reports 9).
// Ports:
//   clk, rst_n     clock, async active-low reset
//   clear          sync abort of the current hand/result
//   card_valid/card_ready/card_in   card input stream ({rank[5:2], suit[1:0]})
//   result_valid/result_ready       result handshake
//   hand_rank      0 high card .. 8 straight flush (9 royal when enabled)
//   dup_err        a card repeated within the hand
//   bad_card_err   a card with rank > 12 was received (hand_rank forced 0)
//   cards_seen     cards accepted in the current hand
module hand_rank_stream_eval
  import poker_pkg::*;
#(
  parameter  int unsigned HAND_SIZE = 5,
  localparam int unsigned CNT_W     = $clog2(HAND_SIZE + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             card_valid,
  input  logic [5:0]       card_in,
  output logic             card_ready,
  output logic             result_valid,
  input  logic             result_ready,
  output logic [3:0]       hand_rank,
  output logic             dup_err,
  output logic             bad_card_err,
  output logic [CNT_W-1:0] cards_seen
);

  if (HAND_SIZE < 5 || HAND_SIZE > 7) begin : g_bad_hand_size
    $error("hand_rank_stream_eval: HAND_SIZE must be 5..7");
  end

  typedef enum logic [1:0] {
    S_COLLECT = 2'd0,
    S_EVAL    = 2'd1,
    S_DONE    = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [NUM_SUITS-1:0][NUM_RANKS-1:0] suit_mask_q, suit_mask_d;
  logic [CNT_W-1:0] cards_seen_q, cards_seen_d;
  logic             dup_err_q, dup_err_d;
  logic             bad_card_err_q, bad_card_err_d;
  logic [3:0]       hand_rank_q, hand_rank_d;

  card_t card_c;
  assign card_c = card_t'(card_in);

  // ---------------- straight detection ----------------
  logic [NUM_RANKS-1:0] any_mask_c;
  logic [NUM_SUITS-1:0] suit_sf_c;
  logic [NUM_SUITS-1:0] suit_ace_c;
  logic                 any_straight_c;
  logic                 any_ace_unused;

  assign any_mask_c = suit_mask_q[0] | suit_mask_q[1] | suit_mask_q[2] | suit_mask_q[3];

  for (genvar s = 0; s < NUM_SUITS; s++) begin : g_suit_sd
    straight_detect u_sd_suit (
      .mask     (suit_mask_q[s]),
      .found    (suit_sf_c[s]),
      .ace_high (suit_ace_c[s])
    );
  end

  straight_detect u_sd_any (
    .mask     (any_mask_c),
    .found    (any_straight_c),
    .ace_high (any_ace_unused)
  );

  // Straight-flush code: royal only when the same suit runs 10..A.
  hand_rank_e sf_class_c;
`ifdef HAND_ROYAL_FLUSH_EN
  always_comb begin
    sf_class_c = (|(suit_sf_c & suit_ace_c)) ? ROYAL_FLUSH : STRAIGHT_FLUSH;
  end
`else
  logic suit_ace_unused;
  assign suit_ace_unused = ^suit_ace_c;
  always_comb begin
    sf_class_c = STRAIGHT_FLUSH;
  end
`endif

  // ---------------- rank / suit histograms ----------------
  logic [2:0] rank_cnt_c [NUM_RANKS];
  logic [2:0] suit_cnt_c [NUM_SUITS];

  always_comb begin
    for (int unsigned r = 0; r < NUM_RANKS; r++) begin
      rank_cnt_c[r] = 3'(suit_mask_q[0][r]) + 3'(suit_mask_q[1][r]) +
                      3'(suit_mask_q[2][r]) + 3'(suit_mask_q[3][r]);
    end
    for (int unsigned s = 0; s < NUM_SUITS; s++) begin
      suit_cnt_c[s] = 3'($countones(suit_mask_q[s]));
    end
  end

  // ---------------- classification (first match wins) ----------------
  logic       four_c;
  logic       flush_c;
  logic [3:0] n_trip_c;
  logic [3:0] n_pair_plus_c;
  logic [3:0] n_pair_exact_c;
  hand_rank_e class_c;

  always_comb begin
    four_c         = 1'b0;
    flush_c        = 1'b0;
    n_trip_c       = 4'd0;
    n_pair_plus_c  = 4'd0;
    n_pair_exact_c = 4'd0;
    for (int unsigned r = 0; r < NUM_RANKS; r++) begin
      if (rank_cnt_c[r] == 3'd4) four_c = 1'b1;
      if (rank_cnt_c[r] == 3'd3) n_trip_c = n_trip_c + 4'd1;
      if (rank_cnt_c[r] >= 3'd2) n_pair_plus_c = n_pair_plus_c + 4'd1;
      if (rank_cnt_c[r] == 3'd2) n_pair_exact_c = n_pair_exact_c + 4'd1;
    end
    for (int unsigned s = 0; s < NUM_SUITS; s++) begin
      if (suit_cnt_c[s] >= 3'd5) flush_c = 1'b1;
    end

    class_c = HIGH_CARD;
    if (|suit_sf_c)                                       class_c = sf_class_c;
    else if (four_c)                                      class_c = FOUR_KIND;
    else if (n_trip_c != 4'd0 && n_pair_plus_c >= 4'd2)   class_c = FULL_HOUSE;
    else if (flush_c)                                     class_c = FLUSH;
    else if (any_straight_c)                              class_c = STRAIGHT;
    else if (n_trip_c != 4'd0)                            class_c = THREE_KIND;
    else if (n_pair_plus_c >= 4'd2)                       class_c = TWO_PAIR;
    else if (n_pair_exact_c == 4'd1)                      class_c = PAIR;
  end

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_COLLECT;
    else        state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = S_COLLECT;
    end else begin
      case (state_q)
        S_COLLECT: if (card_valid && cards_seen_q == CNT_W'(HAND_SIZE - 1)) state_d = S_EVAL;
        S_EVAL:    state_d = S_DONE;
        S_DONE:    if (result_ready) state_d = S_COLLECT;
        default:   state_d = S_COLLECT;
      endcase
    end
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    card_ready   = (state_q == S_COLLECT);
    result_valid = (state_q == S_DONE);
  end

  // ---------------- datapath next values ----------------
  always_comb begin
    suit_mask_d    = suit_mask_q;
    cards_seen_d   = cards_seen_q;
    dup_err_d      = dup_err_q;
    bad_card_err_d = bad_card_err_q;
    hand_rank_d    = hand_rank_q;

    if (clear || (state_q == S_DONE && result_ready)) begin
      suit_mask_d    = '0;
      cards_seen_d   = '0;
      dup_err_d      = 1'b0;
      bad_card_err_d = 1'b0;
      hand_rank_d    = 4'd0;
    end else if (state_q == S_COLLECT && card_valid) begin
      // Illegal and duplicate cards still count toward the hand length.
      cards_seen_d = cards_seen_q + CNT_W'(1);
      if (card_c.rank > MAX_RANK) begin
        bad_card_err_d = 1'b1;
      end else if (suit_mask_q[card_c.suit][card_c.rank]) begin
        dup_err_d = 1'b1;
      end else begin
        suit_mask_d[card_c.suit][card_c.rank] = 1'b1;
      end
    end else if (state_q == S_EVAL) begin
      hand_rank_d = bad_card_err_q ? 4'(HIGH_CARD) : 4'(class_c);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      suit_mask_q    <= '0;
      cards_seen_q   <= '0;
      dup_err_q      <= 1'b0;
      bad_card_err_q <= 1'b0;
      hand_rank_q    <= 4'd0;
    end else begin
      suit_mask_q    <= suit_mask_d;
      cards_seen_q   <= cards_seen_d;
      dup_err_q      <= dup_err_d;
      bad_card_err_q <= bad_card_err_d;
      hand_rank_q    <= hand_rank_d;
    end
  end

  assign hand_rank    = hand_rank_q;
  assign dup_err      = dup_err_q;
  assign bad_card_err = bad_card_err_q;
  assign cards_seen   = cards_seen_q;

endmodule

// File: tb/tb_hand_rank_stream_eval.sv
// Bench for hand_rank_stream_eval: one 5-card and one 7-card instance,
// scoreboard queues filled by the stimulus and drained by a result monitor.
module tb_hand_rank_stream_eval;

  typedef logic [5:0] hand_t [7];
  typedef struct {
    int rank;
    int dup;
    int bad;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clear        [2];
  logic       card_valid   [2];
  logic [5:0] card_in      [2];
  logic       card_ready   [2];
  logic       result_valid [2];
  logic       result_ready [2];
  logic [3:0] hand_rank    [2];
  logic       dup_err      [2];
  logic       bad_card_err [2];
  logic [2:0] cards_seen   [2];

  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;
  bit   rnd_ready = 1'b0;
  exp_t q0[$];
  exp_t q1[$];
  int   hs_cyc0[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  hand_rank_stream_eval #(.HAND_SIZE(5)) u_dut5 (
    .clk(clk), .rst_n(rst_n), .clear(clear[0]), .card_valid(card_valid[0]),
    .card_in(card_in[0]), .card_ready(card_ready[0]), .result_valid(result_valid[0]),
    .result_ready(result_ready[0]), .hand_rank(hand_rank[0]), .dup_err(dup_err[0]),
    .bad_card_err(bad_card_err[0]), .cards_seen(cards_seen[0])
  );

  hand_rank_stream_eval #(.HAND_SIZE(7)) u_dut7 (
    .clk(clk), .rst_n(rst_n), .clear(clear[1]), .card_valid(card_valid[1]),
    .card_in(card_in[1]), .card_ready(card_ready[1]), .result_valid(result_valid[1]),
    .result_ready(result_ready[1]), .hand_rank(hand_rank[1]), .dup_err(dup_err[1]),
    .bad_card_err(bad_card_err[1]), .cards_seen(cards_seen[1])
  );

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [5:0] mk(input int r, input int s);
    return {4'(r), 2'(s)};
  endfunction

  // Five consecutive ranks anywhere in 2..A, or A-2-3-4-5.
  function automatic bit has_straight(input int m);
    if (((m >> 12) & 1) == 1 && (m & 15) == 15) return 1'b1;
    for (int lo = 0; lo <= 8; lo++) if (((m >> lo) & 31) == 31) return 1'b1;
    return 1'b0;
  endfunction

  // Reference classifier built directly from the hand-ranking rules.
  function automatic exp_t model(input hand_t h, input int n);
    exp_t e;
    int suit_set [4];
    int rc [13];
    int sc [4];
    int r, s, any, n3, n2p, n2;
    bit sf, royal, four, fl;
    e = '{rank: 0, dup: 0, bad: 0};
    for (int i = 0; i < 4; i++) begin suit_set[i] = 0; sc[i] = 0; end
    for (int i = 0; i < 13; i++) rc[i] = 0;
    for (int i = 0; i < n; i++) begin
      r = int'(h[i][5:2]);
      s = int'(h[i][1:0]);
      if (r > 12) e.bad = 1;
      else if (((suit_set[s] >> r) & 1) == 1) e.dup = 1;
      else begin
        suit_set[s] = suit_set[s] | (1 << r);
        rc[r]++;
        sc[s]++;
      end
    end
    if (e.bad == 1) return e;
    sf = 0; royal = 0; fl = 0; four = 0; any = 0; n3 = 0; n2p = 0; n2 = 0;
    for (int i = 0; i < 4; i++) begin
      any = any | suit_set[i];
      if (has_straight(suit_set[i])) sf = 1;
      if (((suit_set[i] >> 8) & 31) == 31) royal = 1;
      if (sc[i] >= 5) fl = 1;
    end
    for (int i = 0; i < 13; i++) begin
      if (rc[i] == 4) four = 1;
      if (rc[i] == 3) n3++;
      if (rc[i] >= 2) n2p++;
      if (rc[i] == 2) n2++;
    end
`ifdef HAND_ROYAL_FLUSH_EN
    if (sf) e.rank = royal ? 9 : 8;
`else
    if (sf) e.rank = 8;
`endif
    else if (four)                e.rank = 7;
    else if (n3 >= 1 && n2p >= 2) e.rank = 6;
    else if (fl)                  e.rank = 5;
    else if (has_straight(any))   e.rank = 4;
    else if (n3 >= 1)             e.rank = 3;
    else if (n2p >= 2)            e.rank = 2;
    else if (n2 == 1)             e.rank = 1;
    return e;
  endfunction

  task automatic push_exp(input int d, input int rank, input int dup, input int bad);
    exp_t e;
    e = '{rank: rank, dup: dup, bad: bad};
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic push_model(input int d, input hand_t h, input int n);
    exp_t e;
    e = model(h, n);
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  // Present one card; returns just after the accepting edge.
  task automatic drive_card(input int d, input logic [5:0] c);
    int budget;
    budget = 0;
    card_valid[d] = 1'b1;
    card_in[d]    = c;
    forever begin
      @(negedge clk);
      if (card_ready[d]) break;
      budget++;
      if (budget > 60) begin
        check("card_ready_timeout", 0, 1);
        card_valid[d] = 1'b0;
        return;
      end
      @(posedge clk); #1;
      if (rnd_ready) result_ready[d] = 1'($urandom_range(0, 1));
    end
    @(posedge clk); #1;
    card_valid[d] = 1'b0;
    if (rnd_ready) result_ready[d] = 1'($urandom_range(0, 1));
  endtask

  task automatic send_hand(input int d, input hand_t h, input int n);
    for (int i = 0; i < n; i++) drive_card(d, h[i]);
  endtask

  function automatic hand_t rand_hand(input int n);
    hand_t h;
    int mode, base, fs, r, s;
    mode = int'($urandom_range(0, 3));
    base = int'($urandom_range(0, 9));
    fs   = int'($urandom_range(0, 3));
    for (int i = 0; i < 7; i++) h[i] = 6'd0;
    for (int i = 0; i < n; i++) begin
      r = int'($urandom_range(0, 12));
      s = int'($urandom_range(0, 3));
      case (mode)
        1: s = int'($urandom_range(0, 1));
        2: begin
             r = (base + 12 + int'($urandom_range(0, 4))) % 13;
             if ($urandom_range(0, 1) == 1) s = fs;
           end
        3: r = (base + int'($urandom_range(0, 2))) % 13;
        default: ;
      endcase
      if ($urandom_range(0, 39) == 0) r = int'($urandom_range(13, 15));
      h[i] = mk(r, s);
    end
    return h;
  endfunction

  // Monitor: every accepted result is compared with the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    int   sz;
    for (int d = 0; d < 2; d++) begin
      if (rst_n && result_valid[d] && result_ready[d]) begin
        sz = (d == 0) ? q0.size() : q1.size();
        check($sformatf("result_expected_d%0d", d), (sz > 0) ? 1 : 0, 1);
        if (sz > 0) begin
          e = (d == 0) ? q0.pop_front() : q1.pop_front();
          check($sformatf("hand_rank_d%0d", d), int'(hand_rank[d]), e.rank);
          check($sformatf("dup_err_d%0d", d), int'(dup_err[d]), e.dup);
          check($sformatf("bad_card_err_d%0d", d), int'(bad_card_err[d]), e.bad);
        end
        if (d == 0) hs_cyc0.push_back(cyc);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    hand_t h;
    int    rv, gap;
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      clear[d] = 1'b0; card_valid[d] = 1'b0; card_in[d] = 6'd0; result_ready[d] = 1'b1;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("rst_card_ready_d%0d", d), int'(card_ready[d]), 1);
      check($sformatf("rst_result_valid_d%0d", d), int'(result_valid[d]), 0);
      check($sformatf("rst_hand_rank_d%0d", d), int'(hand_rank[d]), 0);
      check($sformatf("rst_cards_seen_d%0d", d), int'(cards_seen[d]), 0);
      check($sformatf("rst_errs_d%0d", d), int'({dup_err[d], bad_card_err[d]}), 0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Low straight 2..6; result visible one edge after the EVAL cycle.
    h = '{mk(0,0), mk(1,1), mk(2,2), mk(3,3), mk(4,0), 6'd0, 6'd0};
    push_exp(0, 4, 0, 0);
    send_hand(0, h, 5);
    check("lat_eval_cycle_valid", int'(result_valid[0]), 0);
    check("lat_cards_seen_full", int'(cards_seen[0]), 5);
    @(posedge clk); #1;
    check("lat_done_valid", int'(result_valid[0]), 1);
    check("lat_done_card_ready", int'(card_ready[0]), 0);
    @(posedge clk); #1;

    // Wheel straight flush in spades.
    h = '{mk(12,3), mk(0,3), mk(1,3), mk(2,3), mk(3,3), 6'd0, 6'd0};
    push_exp(0, 8, 0, 0);
    send_hand(0, h, 5);

    // 10..A of spades.
    h = '{mk(8,3), mk(9,3), mk(10,3), mk(11,3), mk(12,3), 6'd0, 6'd0};
`ifdef HAND_ROYAL_FLUSH_EN
    push_exp(0, 9, 0, 0);
`else
    push_exp(0, 8, 0, 0);
`endif
    send_hand(0, h, 5);

    // Illegal rank 15, then a repeated 9H.
    h = '{6'h3C, mk(0,0), mk(1,1), mk(2,2), mk(7,3), 6'd0, 6'd0};
    push_exp(0, 0, 0, 1);
    send_hand(0, h, 5);
    h = '{mk(7,2), mk(7,2), mk(0,0), mk(3,1), mk(11,3), 6'd0, 6'd0};
    push_exp(0, 0, 1, 0);
    send_hand(0, h, 5);

    // 7-card: full house with K pair, then with 2 pair, then a plain flush.
    h = '{mk(5,2), mk(5,1), mk(5,3), mk(11,0), mk(11,1), mk(0,2), mk(7,3)};
    push_exp(1, 6, 0, 0);
    send_hand(1, h, 7);
    h = '{mk(5,2), mk(5,1), mk(5,3), mk(11,0), mk(0,0), mk(0,2), mk(7,3)};
    push_exp(1, 6, 0, 0);
    send_hand(1, h, 7);
    h = '{mk(0,2), mk(3,2), mk(6,2), mk(9,2), mk(11,2), mk(1,3), mk(2,3)};
    push_exp(1, 5, 0, 0);
    send_hand(1, h, 7);

    // Backpressure: outputs held while result_ready is low.
    repeat (3) @(posedge clk); #1;
    result_ready[0] = 1'b0;
    h = '{mk(0,0), mk(0,1), mk(3,2), mk(3,3), mk(7,0), 6'd0, 6'd0};
    send_hand(0, h, 5);
    @(posedge clk); #1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("hold_result_valid", int'(result_valid[0]), 1);
      check("hold_hand_rank", int'(hand_rank[0]), 2);
      check("hold_card_ready", int'(card_ready[0]), 0);
      @(posedge clk); #1;
    end
    push_exp(0, 2, 0, 0);
    result_ready[0] = 1'b1;
    @(posedge clk); #1;

    // clear together with the 3rd card: card dropped, hand restarts.
    drive_card(0, mk(0,0));
    drive_card(0, mk(1,0));
    card_valid[0] = 1'b1; card_in[0] = mk(2,0); clear[0] = 1'b1;
    @(negedge clk);
    check("clear_card_ready", int'(card_ready[0]), 1);
    @(posedge clk); #1;
    clear[0] = 1'b0; card_valid[0] = 1'b0;
    check("clear_cards_seen", int'(cards_seen[0]), 0);
    h = '{mk(11,2), mk(10,2), mk(9,2), mk(8,2), mk(7,2), 6'd0, 6'd0};
    push_exp(0, 8, 0, 0);
    send_hand(0, h, 5);
    repeat (2) @(posedge clk); #1;

    // clear while a result waits in DONE: result dropped.
    result_ready[0] = 1'b0;
    h = '{mk(4,0), mk(4,1), mk(4,2), mk(4,3), mk(9,0), 6'd0, 6'd0};
    send_hand(0, h, 5);
    @(posedge clk); #1;
    @(negedge clk);
    check("clr_done_valid_before", int'(result_valid[0]), 1);
    @(posedge clk); #1;
    clear[0] = 1'b1;
    @(posedge clk); #1;
    clear[0] = 1'b0;
    check("clr_done_valid_after", int'(result_valid[0]), 0);
    check("clr_done_card_ready", int'(card_ready[0]), 1);
    check("clr_done_hand_rank", int'(hand_rank[0]), 0);
    result_ready[0] = 1'b1;

    // Async reset while DONE.
    result_ready[0] = 1'b0;
    h = '{mk(6,0), mk(6,1), mk(6,2), mk(2,3), mk(9,0), 6'd0, 6'd0};
    send_hand(0, h, 5);
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_done_valid_before", int'(result_valid[0]), 1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_valid", int'(result_valid[0]), 0);
    check("rst_async_card_ready", int'(card_ready[0]), 1);
    check("rst_async_hand_rank", int'(hand_rank[0]), 0);
    @(negedge clk); #1;
    rst_n = 1'b1;
    result_ready[0] = 1'b1;
    @(posedge clk); #1;

    // Back-to-back hands with result_ready high: one hand per HAND_SIZE+2 cycles.
    for (int k = 0; k < 3; k++) begin
      h = rand_hand(5);
      push_model(0, h, 5);
      send_hand(0, h, 5);
    end
    repeat (3) @(posedge clk); #1;
    if (hs_cyc0.size() >= 2) gap = hs_cyc0[hs_cyc0.size()-1] - hs_cyc0[hs_cyc0.size()-2];
    else gap = -1;
    check("throughput_gap", gap, 7);

    // Randomized hands on both sizes with random result backpressure.
    rnd_ready = 1'b1;
    for (int k = 0; k < 40; k++) begin
      h = rand_hand(5);
      push_model(0, h, 5);
      send_hand(0, h, 5);
      h = rand_hand(7);
      push_model(1, h, 7);
      send_hand(1, h, 7);
    end
    rnd_ready = 1'b0;
    result_ready[0] = 1'b1;
    result_ready[1] = 1'b1;

    rv = 0;
    while ((q0.size() + q1.size()) != 0 && rv < 200) begin
      @(posedge clk); #1;
      rv++;
    end
    check("scoreboard_drained", q0.size() + q1.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
